// File: rtl/rover_sprite_compositor_if.sv
// Sprite configuration write port: one sprite record per accepted valid/ready beat.
interface rover_sprite_compositor_if #(
  parameter int IDX_W      = 2,
  parameter int ALPHA_BITS = 2
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [IDX_W-1:0]      cfg_index;
  logic [10:0]           cfg_x;
  logic [9:0]            cfg_y;
  logic [23:0]           cfg_color;
  logic [ALPHA_BITS-1:0] cfg_alpha;
  logic                  cfg_enable;

  modport master (output cfg_valid, cfg_index, cfg_x, cfg_y, cfg_color, cfg_alpha, cfg_enable,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_index, cfg_x, cfg_y, cfg_color, cfg_alpha, cfg_enable,
                  output cfg_ready);
endinterface

// File: rtl/rover_sprite_compositor.sv
// XVGA sprite compositor: per-sprite shadow/active banks swapped at vsync fall,
// two-stage hit/blend pipeline in priority order over a background color.
module rover_sprite_lane #(
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 64,
  parameter int ALPHA_BITS = 2
) (
  input  logic                  vclock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  commit,
  input  logic [10:0]           wr_x,
  input  logic [9:0]            wr_y,
  input  logic [23:0]           wr_color,
  input  logic [ALPHA_BITS-1:0] wr_alpha,
  input  logic                  wr_enable,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  output logic                  hit,
  output logic [23:0]           act_color,
  output logic [ALPHA_BITS-1:0] act_alpha
);
  typedef struct packed {
    logic                  en;
    logic [10:0]           x;
    logic [9:0]            y;
    logic [23:0]           color;
    logic [ALPHA_BITS-1:0] alpha;
  } sprite_t;

  localparam sprite_t SPR_RST = '{en: 1'b0, x: 11'd0, y: 10'd0, color: 24'd0,
                                  alpha: {ALPHA_BITS{1'b1}}};

  sprite_t     sh_q, sh_d, ac_q, ac_d;
  logic [11:0] x_end;
  logic [10:0] y_end;

  always_comb begin
    sh_d = sh_q;
    ac_d = ac_q;
    if (wr_en)  sh_d = '{en: wr_enable, x: wr_x, y: wr_y, color: wr_color, alpha: wr_alpha};
    if (commit) ac_d = sh_q;
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= SPR_RST;
      ac_q <= SPR_RST;
    end else begin
      sh_q <= sh_d;
      ac_q <= ac_d;
    end
  end

  // One bit wider so sprites near the right/bottom edge clip instead of wrapping.
  assign x_end     = {1'b0, ac_q.x} + 12'(SPRITE_W);
  assign y_end     = {1'b0, ac_q.y} + 11'(SPRITE_H);
  assign hit       = ac_q.en && (hcount >= ac_q.x) && ({1'b0, hcount} < x_end) &&
                     (vcount >= ac_q.y) && ({1'b0, vcount} < y_end);
  assign act_color = ac_q.color;
  assign act_alpha = ac_q.alpha;
endmodule

module rover_sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          IDX_W       = 2,
  parameter int          SPRITE_W    = 64,
  parameter int          SPRITE_H    = 64,
  parameter int          ALPHA_BITS  = 2,
  parameter logic [23:0] BG_COLOR    = 24'h00_00_00
) (
  input  logic                     vclock,
  input  logic                     reset_n,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     blank,
  rover_sprite_compositor_if.slave cfg,
  output logic                     phsync,
  output logic                     pvsync,
  output logic                     pblank,
  output logic [23:0]              pixel,
  output logic                     commit_pulse,
  output logic [15:0]              frame_count
);
  localparam int NS = NUM_SPRITES;
  localparam int AB = ALPHA_BITS;

  logic                    vsync_d_q, vsync_d_d, ready_en_q, ready_en_d;
  logic                    commit_pulse_q, commit_pulse_d, commit, wr_acc;
  logic [15:0]             frame_count_q, frame_count_d;
  logic [NS-1:0]           wr_en, hit_s0, hit_q, hit_d;
  logic [NS-1:0][23:0]     act_color, col_q, col_d;
  logic [NS-1:0][AB-1:0]   act_alpha, alp_q, alp_d;
  logic [1:0][2:0]         sync_pipe_q, sync_pipe_d;  // {hsync, vsync, blank} per stage
  logic [23:0]             pixel_q, pixel_d, blend;

  assign commit         = vsync_d_q & ~vsync;
  assign cfg.cfg_ready  = ready_en_q & ~commit;
  assign wr_acc         = cfg.cfg_valid & cfg.cfg_ready;

  generate
    for (genvar i = 0; i < NS; i++) begin : g_lane
      assign wr_en[i] = wr_acc && (cfg.cfg_index == IDX_W'(i));
      rover_sprite_lane #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ALPHA_BITS(AB)) u_lane (
        .vclock    (vclock),
        .reset_n   (reset_n),
        .wr_en     (wr_en[i]),
        .commit    (commit),
        .wr_x      (cfg.cfg_x),
        .wr_y      (cfg.cfg_y),
        .wr_color  (cfg.cfg_color),
        .wr_alpha  (cfg.cfg_alpha),
        .wr_enable (cfg.cfg_enable),
        .hcount    (hcount),
        .vcount    (vcount),
        .hit       (hit_s0[i]),
        .act_color (act_color[i]),
        .act_alpha (act_alpha[i])
      );
    end
  endgenerate

  // (c*w + acc*(S-w)) >> AB with w = alpha+1; peak is 255*S so AB+8 bits suffice.
  function automatic logic [7:0] mix(input logic [7:0] c, input logic [7:0] acc,
                                     input logic [AB-1:0] al);
    logic [AB:0]   w;
    logic [AB+7:0] sum;
    w   = {1'b0, al} + (AB+1)'(1);
    sum = (AB+8)'(c) * (AB+8)'(w) + (AB+8)'(acc) * (AB+8)'((AB+1)'(1 << AB) - w);
    return 8'(sum >> AB);
  endfunction

  always_comb begin
    vsync_d_d      = vsync;
    ready_en_d     = 1'b1;
    commit_pulse_d = commit;
    frame_count_d  = frame_count_q + 16'(commit);
    hit_d          = hit_s0;
    col_d          = act_color;
    alp_d          = act_alpha;
    sync_pipe_d    = {sync_pipe_q[0], {hsync, vsync, blank}};
    blend          = BG_COLOR;
    for (int i = 0; i < NS; i++) begin
      if (hit_q[i]) begin
        for (int ch = 0; ch < 3; ch++)
          blend[ch*8 +: 8] = mix(col_q[i][ch*8 +: 8], blend[ch*8 +: 8], alp_q[i]);
      end
    end
    pixel_d = sync_pipe_q[0][0] ? 24'h0 : blend;
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d_q      <= 1'b0;
      ready_en_q     <= 1'b0;
      commit_pulse_q <= 1'b0;
      frame_count_q  <= 16'd0;
      hit_q          <= '0;
      col_q          <= '0;
      alp_q          <= '0;
      sync_pipe_q    <= '1;
      pixel_q        <= 24'h0;
    end else begin
      vsync_d_q      <= vsync_d_d;
      ready_en_q     <= ready_en_d;
      commit_pulse_q <= commit_pulse_d;
      frame_count_q  <= frame_count_d;
      hit_q          <= hit_d;
      col_q          <= col_d;
      alp_q          <= alp_d;
      sync_pipe_q    <= sync_pipe_d;
      pixel_q        <= pixel_d;
    end
  end

  assign pixel                   = pixel_q;
  assign {phsync, pvsync, pblank} = sync_pipe_q[1];
  assign commit_pulse            = commit_pulse_q;
  assign frame_count             = frame_count_q;
endmodule

// File: tb/tb_rover_sprite_compositor.sv
// Scoreboard bench: driver pushes model-predicted outputs, negedge monitor pops and compares.
module tb_rover_sprite_compositor;
  localparam int NS = 3, AB = 2, SW = 64, SH = 64;

  logic        vclock = 1'b0, reset_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic        phsync, pvsync, pblank, commit_pulse;
  logic [23:0] pixel;
  logic [15:0] frame_count;

  rover_sprite_compositor_if #(.IDX_W(2), .ALPHA_BITS(AB)) cfg_if();

  rover_sprite_compositor #(.NUM_SPRITES(NS), .IDX_W(2), .SPRITE_W(SW), .SPRITE_H(SH),
                            .ALPHA_BITS(AB), .BG_COLOR(24'h000000)) dut (
    .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .cfg(cfg_if),
    .phsync(phsync), .pvsync(pvsync), .pblank(pblank), .pixel(pixel),
    .commit_pulse(commit_pulse), .frame_count(frame_count));

  initial forever #5 vclock = ~vclock;

  int cyc = 0;
  always @(posedge vclock) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit en; int x; int y; int c; int a; } spr_t;
  spr_t shad[NS], act[NS];
  typedef struct { logic [23:0] px; bit hs; bit vs; bit bl; int due; } pix_t;
  typedef struct { bit pulse; int fc; int due; } frm_t;
  pix_t pq[$];
  frm_t fq[$];
  int   fc_exp = 0;
  bit   vs_prev = 1'b1, wr_pend = 1'b0;

  task automatic reset_model();
    for (int i = 0; i < NS; i++) begin
      shad[i] = '{0, 0, 0, 0, (1 << AB) - 1};
      act[i]  = shad[i];
    end
    fc_exp = 0;
    pq.delete();
    fq.delete();
  endtask

  // Straight from the rules: rectangle test, then weighted average per channel.
  function automatic logic [23:0] model_pixel(input int h, input int v);
    int acc[3];
    int w, c;
    acc = '{0, 0, 0};
    for (int i = 0; i < NS; i++) begin
      if (act[i].en && h >= act[i].x && h < act[i].x + SW && v >= act[i].y && v < act[i].y + SH) begin
        w = act[i].a + 1;
        for (int ch = 0; ch < 3; ch++) begin
          c = (act[i].c >> (8 * ch)) & 255;
          acc[ch] = (c * w + acc[ch] * ((1 << AB) - w)) / (1 << AB);
        end
      end
    end
    return 24'((acc[2] << 16) | (acc[1] << 8) | acc[0]);
  endfunction

  task automatic wr(input int idx, input int x, input int y, input int c, input int a, input bit en);
    cfg_if.cfg_index  = 2'(idx);
    cfg_if.cfg_x      = 11'(x);
    cfg_if.cfg_y      = 10'(y);
    cfg_if.cfg_color  = 24'(c);
    cfg_if.cfg_alpha  = AB'(a);
    cfg_if.cfg_enable = en;
    cfg_if.cfg_valid  = 1'b1;
    wr_pend = 1'b1;
  endtask

  // Called just after a posedge; returns just after the next one.
  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit bl,
                       input int exp_px = -1);
    bit   commit, acc;
    pix_t e;
    frm_t f;
    hcount = 11'(h); vcount = 10'(v); hsync = hs; vsync = vs; blank = bl;
    commit  = vs_prev && !vs;
    vs_prev = vs;
    e.px  = bl ? 24'h0 : (exp_px >= 0 ? 24'(exp_px) : model_pixel(h, v));
    e.hs  = hs; e.vs = vs; e.bl = bl; e.due = cyc + 2;
    pq.push_back(e);
    acc = wr_pend && !commit;
    if (acc && int'(cfg_if.cfg_index) < NS)
      shad[cfg_if.cfg_index] = '{cfg_if.cfg_enable, int'(cfg_if.cfg_x), int'(cfg_if.cfg_y),
                                 int'(cfg_if.cfg_color), int'(cfg_if.cfg_alpha)};
    if (commit) begin
      act    = shad;
      fc_exp = (fc_exp + 1) & 16'hffff;
    end
    f.pulse = commit; f.fc = fc_exp; f.due = cyc + 1;
    fq.push_back(f);
    @(negedge vclock);
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!commit));
    @(posedge vclock); #1;
    if (acc) begin
      wr_pend = 1'b0;
      cfg_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic idle();
    drive(0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic vpulse(input int len);
    for (int k = 0; k < len; k++) drive(0, 770, 1'b1, 1'b0, 1'b1);
    drive(0, 771, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic reset_checks();
    @(negedge vclock);
    chk("rst_pixel", 32'(pixel), 32'h0);
    chk("rst_phsync", 32'(phsync), 32'd1);
    chk("rst_pvsync", 32'(pvsync), 32'd1);
    chk("rst_pblank", 32'(pblank), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_commit_pulse", 32'(commit_pulse), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge vclock); #1;
    reset_n = 1'b1;
    @(posedge vclock); #1;
    vs_prev = vsync;
  endtask

  always @(negedge vclock) begin : monitor
    pix_t e;
    frm_t f;
    if (reset_n) begin
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        e = pq.pop_front();
        if (e.due != cyc) chk("pix_due", 32'(cyc), 32'(e.due));
        else begin
          chk("pixel", 32'(pixel), 32'(e.px));
          chk("phsync", 32'(phsync), 32'(e.hs));
          chk("pvsync", 32'(pvsync), 32'(e.vs));
          chk("pblank", 32'(pblank), 32'(e.bl));
        end
      end
      while (fq.size() > 0 && fq[0].due <= cyc) begin
        f = fq.pop_front();
        if (f.due != cyc) chk("frm_due", 32'(cyc), 32'(f.due));
        else begin
          chk("commit_pulse", 32'(commit_pulse), 32'(f.pulse));
          chk("frame_count", 32'(frame_count), 32'(f.fc));
        end
      end
    end
  end

  initial begin
    int h, v, j;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_index = '0; cfg_if.cfg_x = '0; cfg_if.cfg_y = '0;
    cfg_if.cfg_color = '0; cfg_if.cfg_alpha = '0; cfg_if.cfg_enable = 1'b0;
    reset_model();
    hcount = 11'd512; vcount = 10'd300; blank = 1'b0;
    repeat (3) @(posedge vclock);
    reset_checks();
    hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    release_reset();

    // single opaque sprite
    wr(0, 100, 200, 'hFF0000, 3, 1'b1); idle();
    vpulse(3);
    drive(99, 200, 1, 1, 0, 'h000000);
    drive(100, 200, 1, 1, 0, 'hFF0000);
    drive(163, 200, 1, 1, 0, 'hFF0000);
    drive(164, 200, 1, 1, 0, 'h000000);
    drive(100, 263, 1, 1, 0, 'hFF0000);
    drive(100, 264, 1, 1, 0, 'h000000);
    drive(100, 199, 0, 1, 0, 'h000000);

    // shadow isolation
    wr(0, 300, 200, 'hFF0000, 3, 1'b1); drive(0, 0, 1, 1, 0, 'h000000);
    drive(100, 200, 1, 1, 0, 'hFF0000);
    drive(300, 200, 1, 1, 0, 'h000000);
    vpulse(2);
    drive(300, 200, 1, 1, 0, 'hFF0000);
    drive(100, 200, 1, 1, 0, 'h000000);

    // blend
    wr(1, 330, 200, 'hFFFFFF, 0, 1'b1); idle();
    vpulse(2);
    drive(340, 210, 1, 1, 0, 'hFF3F3F);
    drive(380, 210, 1, 1, 0, 'h3F3F3F);
    drive(310, 210, 1, 1, 0, 'hFF0000);

    // write held across the commit cycle
    idle();
    wr(2, 500, 100, 'h00FF00, 3, 1'b1);
    drive(0, 770, 1, 0, 1);
    drive(0, 770, 1, 0, 1);
    drive(0, 771, 1, 1, 1);
    drive(510, 110, 1, 1, 0, 'h000000);
    vpulse(1);
    drive(510, 110, 1, 1, 0, 'h00FF00);

    // right/bottom clipping and blank gating
    wr(2, 1000, 700, 'h0000FF, 3, 1'b1); idle();
    vpulse(2);
    drive(1023, 700, 1, 1, 0, 'h0000FF);
    drive(1000, 700, 1, 1, 0, 'h0000FF);
    drive(999, 700, 1, 1, 0, 'h000000);
    drive(0, 700, 1, 1, 0, 'h000000);
    drive(1010, 763, 1, 1, 0, 'h0000FF);
    drive(1010, 764, 1, 1, 0, 'h000000);
    drive(1010, 720, 1, 1, 1, 'h000000);

    // out-of-range index is discarded
    wr(3, 0, 0, 'hFFFFFF, 3, 1'b1); idle();
    vpulse(2);
    drive(10, 10, 1, 1, 0, 'h000000);
    drive(1010, 720, 1, 1, 0, 'h0000FF);

    // randomized frames
    for (int fr = 0; fr < 20; fr++) begin
      for (int k = 0; k < 150; k++) begin
        if (!wr_pend && $urandom_range(0, 9) == 0)
          wr($urandom_range(0, 3), $urandom_range(0, 1100), $urandom_range(0, 800),
             int'($urandom & 32'hFFFFFF), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) begin
          h = $urandom_range(0, 2047); v = $urandom_range(0, 1023);
        end else begin
          j = $urandom_range(0, NS - 1);
          h = act[j].x + $urandom_range(0, 80) - 8; v = act[j].y + $urandom_range(0, 80) - 8;
          if (h < 0) h = 0;
          if (v < 0) v = 0;
          if (h > 2047) h = 2047;
          if (v > 1023) v = 1023;
        end
        drive(h, v, $urandom_range(0, 1), 1'b1, $urandom_range(0, 7) == 0);
      end
      vpulse($urandom_range(1, 3));
    end

    // reset mid-line, then a fresh frame
    drive(400, 300, 1, 1, 0);
    reset_n = 1'b0;
    cfg_if.cfg_valid = 1'b0; wr_pend = 1'b0;
    hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    reset_model();
    reset_checks();
    release_reset();
    drive(1010, 720, 1, 1, 0, 'h000000);
    wr(0, 50, 50, 'h123456, 3, 1'b1); idle();
    drive(60, 60, 1, 1, 0, 'h000000);
    vpulse(2);
    drive(60, 60, 1, 1, 0, 'h123456);
    drive(1010, 720, 1, 1, 0, 'h000000);
    repeat (3) idle();
    repeat (3) @(negedge vclock);
    chk("pix_queue_drained", 32'(pq.size()), 32'd0);
    chk("frm_queue_drained", 32'(fq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
